// File: rtl/pcie_inorder_arb_pkg.sv
// -----------------------------------------------------------------------------
// pcie_inorder_arb_pkg
// Shared types and helpers for the in-order PCIe message arbiter.
//   arb_state_t : IDLE (searching for a new message) / LOCK (mid-message)
//   STAT_W      : width of the optional statistics counters
//   rr_pick     : round-robin search over up to PICK_MAX request lines
// -----------------------------------------------------------------------------
package pcie_inorder_arb_pkg;

    localparam int STAT_W   = 32;
    localparam int PICK_MAX = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // First set bit of req starting at ptr and wrapping modulo n (n live lines).
    // Returns found; idx carries the winning line index.
    function automatic logic rr_pick(input  logic [PICK_MAX-1:0] req,
                                     input  int                  ptr,
                                     input  int                  n,
                                     output int                  idx);
        logic found;
        int   j;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < PICK_MAX; k++) begin
            j = (ptr + k) % n;
            if ((k < n) && !found && req[j[3:0]]) begin
                found = 1'b1;
                idx   = j;
            end else begin
                found = found;
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/pcie_inorder_arb_rr_prio_pick.sv
// -----------------------------------------------------------------------------
// rr_prio_pick
// Combinational round-robin pick: rotate the request vector by ptr_i and
// priority-encode the first active line.
//   req_i   [N]    request lines
//   ptr_i   [N_L]  highest-priority line this cycle
//   found_o        at least one request active
//   idx_o   [N_L]  winning line index (valid when found_o)
// -----------------------------------------------------------------------------
module rr_prio_pick
    import pcie_inorder_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int N_L = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [N_L-1:0] ptr_i,
    output logic           found_o,
    output logic [N_L-1:0] idx_o
);

    logic [PICK_MAX-1:0] req_ext_s;
    int                  idx_s;

    // Widen the request vector to the helper's fixed width and run the search.
    always_comb begin
        req_ext_s          = '0;
        req_ext_s[N-1:0]   = req_i;
        idx_s              = 0;
        found_o            = rr_pick(req_ext_s, int'(ptr_i), N, idx_s);
        idx_o              = N_L'(idx_s);
    end

endmodule

// File: rtl/pcie_inorder_arb.sv
// -----------------------------------------------------------------------------
// pcie_inorder_arb
// Shares one downstream message consumer between N in-order ring streams.
// Whole messages of MSG_BEATS beats are granted round-robin; beats of
// different sources are never interleaved. The data path is a zero-latency
// mux, so in_p depends combinationally on out_p.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_v/in_s [N]        per-source beat valid / ring restart marker
//   in_a [N*64]          per-source beat address
//   in_d [N*W]           per-source beat data
//   in_p [N]             per-source pop (beat consumed when in_v&in_p)
//   out_v / out_p        output valid / downstream accept
//   out_a, out_d         granted beat address and data
//   out_src [N_L]        granted source index
//   out_sop, out_eop     first / last beat of message
//   err_sync [N]         sticky: restart observed in the middle of a message
//
// Optional build macro PCIE_INORDER_ARB_STATS_EN adds:
//   stat_msgs [N*32]     per-source completed-message counters (wrapping)
//   stat_stall [32]      cycles with out_v & !out_p (wrapping)
// -----------------------------------------------------------------------------
module pcie_inorder_arb
    import pcie_inorder_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int W         = 512,
    parameter int MSG_BEATS = 4,
    parameter int N_L       = $clog2(N),
    parameter int B_L       = $clog2(MSG_BEATS) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        in_v,
    input  logic [N-1:0]        in_s,
    input  logic [N*64-1:0]     in_a,
    input  logic [N*W-1:0]      in_d,
    output logic [N-1:0]        in_p,
    output logic                out_v,
    input  logic                out_p,
    output logic [63:0]         out_a,
    output logic [W-1:0]        out_d,
    output logic [N_L-1:0]      out_src,
    output logic                out_sop,
    output logic                out_eop,
`ifdef PCIE_INORDER_ARB_STATS_EN
    output logic [N*STAT_W-1:0] stat_msgs,
    output logic [STAT_W-1:0]   stat_stall,
`endif
    output logic [N-1:0]        err_sync
);

    localparam logic [B_L-1:0] LAST_BEAT = B_L'(MSG_BEATS - 1);
    localparam logic [N_L-1:0] LAST_SRC  = N_L'(N - 1);
    localparam bit             SINGLE    = (MSG_BEATS == 1);

    arb_state_t     state_q, state_d;
    logic [N_L-1:0] rr_ptr_q, rr_ptr_d;
    logic [B_L-1:0] beat_cnt_q, beat_cnt_d;
    logic [N_L-1:0] grant_q, grant_d;
    logic [N-1:0]   err_sync_q, err_sync_d;

    logic           pick_found_s;
    logic [N_L-1:0] pick_idx_s;
    logic [N_L-1:0] sel_s;
    logic           restart_s;
    logic [63:0]    a_arr_s [N];
    logic [W-1:0]   d_arr_s [N];

    function automatic logic [N_L-1:0] next_src(input logic [N_L-1:0] s);
        return (s == LAST_SRC) ? '0 : s + N_L'(1);
    endfunction

    rr_prio_pick #(
        .N   (N),
        .N_L (N_L)
    ) u_pick (
        .req_i   (in_v),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found_s),
        .idx_o   (pick_idx_s)
    );

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        assign a_arr_s[gi] = in_a[gi*64 +: 64];
        assign d_arr_s[gi] = in_d[gi*W +: W];
    end

    // While locked only the granted source may drive the output.
    assign sel_s    = (state_q == LOCK) ? grant_q : pick_idx_s;
    assign out_src  = sel_s;
    assign out_a    = a_arr_s[sel_s];
    assign out_d    = d_arr_s[sel_s];
    assign err_sync = err_sync_q;

    // Next-state, handshake and framing logic for the two-state arbiter.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        grant_d    = grant_q;
        err_sync_d = err_sync_q;
        in_p       = '0;
        out_v      = 1'b0;
        out_sop    = 1'b0;
        out_eop    = 1'b0;
        restart_s  = 1'b0;
        case (state_q)
            IDLE: begin
                // sop is only committed once the downstream accepts it.
                if (pick_found_s) begin
                    out_v   = 1'b1;
                    out_sop = 1'b1;
                    out_eop = SINGLE;
                    if (out_p) begin
                        in_p[pick_idx_s] = 1'b1;
                        if (SINGLE) begin
                            rr_ptr_d = next_src(pick_idx_s);
                        end else begin
                            state_d    = LOCK;
                            beat_cnt_d = B_L'(1);
                            grant_d    = pick_idx_s;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOCK: begin
                // A restart mid-message opens a new message on the same
                // source; the partial one is left unterminated.
                restart_s = in_v[grant_q] & in_s[grant_q];
                out_v     = in_v[grant_q];
                out_sop   = restart_s;
                out_eop   = restart_s ? SINGLE : (beat_cnt_q == LAST_BEAT);
                if (restart_s) begin
                    err_sync_d[grant_q] = 1'b1;
                end else begin
                    err_sync_d = err_sync_q;
                end
                if (out_v && out_p) begin
                    in_p[grant_q] = 1'b1;
                    if (out_eop) begin
                        state_d    = IDLE;
                        rr_ptr_d   = next_src(grant_q);
                        beat_cnt_d = '0;
                    end else if (restart_s) begin
                        beat_cnt_d = B_L'(1);
                    end else begin
                        beat_cnt_d = beat_cnt_q + B_L'(1);
                    end
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            grant_q    <= '0;
            err_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            grant_q    <= grant_d;
            err_sync_q <= err_sync_d;
        end
    end

`ifdef PCIE_INORDER_ARB_STATS_EN
    logic [STAT_W-1:0] msgs_q [N];
    logic [STAT_W-1:0] stall_q;

    // Completed-message and stall counters; both wrap on overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                msgs_q[i] <= '0;
            end
            stall_q <= '0;
        end else begin
            if (out_v && out_p && out_eop) begin
                msgs_q[sel_s] <= msgs_q[sel_s] + STAT_W'(1);
            end
            if (out_v && !out_p) begin
                stall_q <= stall_q + STAT_W'(1);
            end
        end
    end

    for (genvar gs = 0; gs < N; gs++) begin : g_stat
        assign stat_msgs[gs*STAT_W +: STAT_W] = msgs_q[gs];
    end
    assign stat_stall = stall_q;
`else
    // Statistics counters are not present in this build.
`endif

endmodule

// File: tb/tb_pcie_inorder_arb.sv
// -----------------------------------------------------------------------------
// tb_pcie_inorder_arb
// Scoreboard bench for pcie_inorder_arb (N=4, W=512, MSG_BEATS=4). Each source
// presents a numbered beat stream; expected beats are queued when a test is
// set up and popped as the DUT transfers them.
// -----------------------------------------------------------------------------
module tb_pcie_inorder_arb;

    localparam int N   = 4;
    localparam int W   = 512;
    localparam int MB  = 4;
    localparam int N_L = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      in_v, in_s, in_p;
    logic [N*64-1:0]   in_a;
    logic [N*W-1:0]    in_d;
    logic              out_v, out_p, out_sop, out_eop;
    logic [63:0]       out_a;
    logic [W-1:0]      out_d;
    logic [N_L-1:0]    out_src;
    logic [N-1:0]      err_sync;
`ifdef PCIE_INORDER_ARB_STATS_EN
    logic [N*32-1:0]   stat_msgs;
    logic [31:0]       stat_stall;
`endif

    always #5 clk = ~clk;

    pcie_inorder_arb #(.N(N), .W(W), .MSG_BEATS(MB)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_v     (in_v),
        .in_s     (in_s),
        .in_a     (in_a),
        .in_d     (in_d),
        .in_p     (in_p),
        .out_v    (out_v),
        .out_p    (out_p),
        .out_a    (out_a),
        .out_d    (out_d),
        .out_src  (out_src),
        .out_sop  (out_sop),
        .out_eop  (out_eop),
`ifdef PCIE_INORDER_ARB_STATS_EN
        .stat_msgs  (stat_msgs),
        .stat_stall (stat_stall),
`endif
        .err_sync (err_sync)
    );

    typedef struct {
        logic [N_L-1:0] src;
        logic           sop;
        logic           eop;
        logic [W-1:0]   d;
        logic [63:0]    a;
    } beat_t;

    beat_t        sb[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           xfers    = 0;
    logic [N-1:0] pop_seen = '0;
    int           avail  [N];
    int           seqn   [N];
    int           rs_seq [N];
    logic [N-1:0] bubble;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk_d(input int s, input int q);
        logic [W-1:0] r;
        for (int k = 0; k < W/32; k++) r[k*32 +: 32] = {8'(s), 24'(q)} + 32'(k);
        return r;
    endfunction

    function automatic logic [63:0] mk_a(input int s, input int q);
        return {16'hA5A5, 16'(s), 32'(q)};
    endfunction

    task automatic push_beat(input int s, input int q, input logic sop, input logic eop);
        beat_t e;
        e.src = N_L'(s);
        e.sop = sop;
        e.eop = eop;
        e.d   = mk_d(s, q);
        e.a   = mk_a(s, q);
        sb.push_back(e);
    endtask

    task automatic push_msgs(input int s, input int q0, input int nm);
        for (int m = 0; m < nm; m++)
            for (int b = 0; b < MB; b++)
                push_beat(s, q0 + m*MB + b, b == 0, b == MB-1);
    endtask

    task automatic load(input int s, input int n);
        avail[s] = n;
        seqn[s]  = 0;
    endtask

    task automatic drive();
        logic v;
        for (int i = 0; i < N; i++) begin
            v              = (avail[i] > 0) && !bubble[i];
            in_v[i]        = v;
            in_s[i]        = v && (seqn[i] == rs_seq[i]);
            in_d[i*W +: W] = mk_d(i, seqn[i]);
            in_a[i*64 +: 64] = mk_a(i, seqn[i]);
        end
    endtask

    // Advance past the next rising edge and retire beats popped last cycle.
    task automatic sync();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (pop_seen[i]) begin
                seqn[i]++;
                avail[i]--;
            end
        end
    endtask

    task automatic cyc(input logic op);
        sync();
        drive();
        out_p = op;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst   = 1'b1;
        out_p = 1'b0;
        bubble = '0;
        for (int i = 0; i < N; i++) begin
            avail[i]  = 0;
            seqn[i]   = 0;
            rs_seq[i] = -1;
        end
        sb.delete();
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string tag, input int bound, output int n);
        n = 0;
        while (sb.size() > 0 && n < bound) begin
            cyc(1'b1);
            n++;
            @(negedge clk);
            #1;
        end
        check_eq({tag, "_drain"}, W'(sb.size()), W'(0));
    endtask

    // Output monitor: compare every presented beat against the queue head.
    always @(negedge clk) begin
        beat_t        e;
        logic [N-1:0] m;
        if (rst) begin
            pop_seen <= '0;
        end else begin
            pop_seen <= in_p;
            if (out_v) begin
                if (sb.size() == 0) begin
                    check_eq("beat_unexpected", W'(1), W'(0));
                end else begin
                    e = sb[0];
                    check_eq("out_src", W'(out_src), W'(e.src));
                    check_eq("out_sop", W'(out_sop), W'(e.sop));
                    check_eq("out_eop", W'(out_eop), W'(e.eop));
                    check_eq("out_d",   out_d,       e.d);
                    check_eq("out_a",   W'(out_a),   W'(e.a));
                    if (out_p) begin
                        m        = '0;
                        m[e.src] = 1'b1;
                        check_eq("pop_mask", W'(in_p), W'(m));
                        void'(sb.pop_front());
                        xfers <= xfers + 1;
                    end else begin
                        check_eq("pop_stall", W'(in_p), W'(0));
                    end
                end
            end else begin
                check_eq("pop_idle", W'(in_p), W'(0));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        int x0;
        rst    = 1'b1;
        in_v   = '0;
        in_s   = '0;
        in_a   = '0;
        in_d   = '0;
        out_p  = 1'b0;
        bubble = '0;
        for (int i = 0; i < N; i++) begin
            avail[i]  = 0;
            seqn[i]   = 0;
            rs_seq[i] = -1;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_eq("rst_out_v",    W'(out_v),    W'(0));
        check_eq("rst_in_p",     W'(in_p),     W'(0));
        check_eq("rst_err_sync", W'(err_sync), W'(0));

        // Full load: whole messages round-robin 0,1,2,3 then wrap to 0.
        do_reset();
        for (int s = 0; s < N; s++) load(s, (s == 0) ? 8 : 4);
        push_msgs(0, 0, 1);
        push_msgs(1, 0, 1);
        push_msgs(2, 0, 1);
        push_msgs(3, 0, 1);
        push_msgs(0, 4, 1);
        drive();
        x0 = xfers;
        drain("rr", 40, c);
        check_eq("rr_cycles", W'(c), W'(20));
        check_eq("rr_xfers",  W'(xfers - x0), W'(20));

        // Single source with downstream toggling accept.
        do_reset();
        load(2, 4);
        push_msgs(2, 0, 1);
        drive();
        x0 = xfers;
        for (int k = 0; k < 7; k++) begin
            cyc((k % 2) == 0);
            @(negedge clk);
            #1;
        end
        check_eq("toggle_xfers", W'(xfers - x0), W'(4));
        check_eq("toggle_left",  W'(sb.size()),  W'(0));

        // Bubble on the locked source must hold the lock.
        do_reset();
        load(1, 4);
        load(3, 4);
        push_msgs(1, 0, 1);
        push_msgs(3, 0, 1);
        drive();
        cyc(1'b1);
        cyc(1'b1);
        bubble[1] = 1'b1;
        repeat (3) begin
            cyc(1'b1);
            @(negedge clk);
            #1;
            check_eq("bubble_out_v", W'(out_v), W'(0));
        end
        bubble[1] = 1'b0;
        drain("bubble", 20, c);

        // Restart at beat 2 of a message on source 0.
        do_reset();
        load(0, 6);
        rs_seq[0] = 2;
        push_beat(0, 0, 1'b1, 1'b0);
        push_beat(0, 1, 1'b0, 1'b0);
        push_beat(0, 2, 1'b1, 1'b0);
        push_beat(0, 3, 1'b0, 1'b0);
        push_beat(0, 4, 1'b0, 1'b0);
        push_beat(0, 5, 1'b0, 1'b1);
        drive();
        drain("restart", 20, c);
        check_eq("restart_err_sync", W'(err_sync), W'(4'b0001));

        // Reset in the middle of a message on source 2.
        sync();
        load(2, 3);
        push_beat(2, 0, 1'b1, 1'b0);
        push_beat(2, 1, 1'b0, 1'b0);
        drive();
        out_p = 1'b1;
        cyc(1'b1);
        @(negedge clk);
        #1;
        check_eq("midrst_err_hold", W'(err_sync),  W'(4'b0001));
        check_eq("midrst_sent",     W'(sb.size()), W'(0));
        do_reset();
        load(0, 4);
        load(3, 4);
        push_msgs(0, 0, 1);
        push_msgs(3, 0, 1);
        drive();
        @(negedge clk);
        #1;
        check_eq("midrst_out_v",    W'(out_v),    W'(1));
        check_eq("midrst_src",      W'(out_src),  W'(0));
        check_eq("midrst_sop",      W'(out_sop),  W'(1));
        check_eq("midrst_err_sync", W'(err_sync), W'(0));
        drain("midrst", 20, c);

`ifdef PCIE_INORDER_ARB_STATS_EN
        // Ten messages from source 3 with five initial stall cycles.
        do_reset();
        load(3, 40);
        push_msgs(3, 0, 10);
        drive();
        repeat (4) cyc(1'b0);
        drain("stats", 60, c);
        check_eq("stat_msgs3", W'(stat_msgs[3*32 +: 32]), W'(10));
        check_eq("stat_msgs0", W'(stat_msgs[0 +: 32]),    W'(0));
        check_eq("stat_stall", W'(stat_stall),            W'(5));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pcie_inorder_arb.md
Name: pcie_inorder_arb

Overview:
- Shares one downstream message consumer between N in-order PCIe ring streams. Each stream is the output of an in-order reassembly stage: valid, start and address, plus a same-cycle pop.
- Grants whole messages of MSG_BEATS beats, round-robin, and never interleaves beats of different sources.
- Tags each output beat with source index and start/end-of-message markers.
- Sits between the per-ring reassembly stages and the shared descriptor parser.

Parameters:
- N, 4, number of source streams (2..16).
- W, 512, data width per beat.
- MSG_BEATS, 4, beats per message (1..256).
- N_L, $clog2(N), source index width.
- B_L, $clog2(MSG_BEATS)+1, beat counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_v  in  N  per-source beat valid.
- in_s  in  N  per-source ring restart; beat is at the ring base address.
- in_a  in  N*64  per-source beat address.
- in_d  in  N*W  per-source beat data.
- in_p  out  N  per-source pop; a beat is consumed when in_v[i]&in_p[i].
- out_v  out  1  output beat valid.
- out_p  in  1  downstream accept.
- out_a  out  64  address of the granted beat.
- out_d  out  W  data of the granted beat.
- out_src  out  N_L  granted source index.
- out_sop  out  1  first beat of message.
- out_eop  out  1  last beat of message.
- err_sync  out  N  sticky: restart seen mid-message.

Behaviour:
- Reset values:
  - out_v=0, in_p=0, err_sync=0.
  - State IDLE, rr_ptr=0, beat_cnt=0.
  - Stats counters 0.
- State machine, two states.
- IDLE:
  - Candidate is the first i with in_v[i], searching rr_ptr, rr_ptr+1, ... mod N.
  - If a candidate exists: out_v=1, out_src=i, out_sop=1, out_eop=(MSG_BEATS==1).
  - If out_p: in_p[i]=1. If MSG_BEATS>1, go to LOCK with beat_cnt=1 and grant_q=i; otherwise stay in IDLE with rr_ptr=i+1 mod N.
  - If !out_p: no state change. The candidate may change next cycle; sop is not yet committed.
- LOCK:
  - Only source grant_q is muxed out; out_v=in_v[grant_q], out_sop=0, out_eop=(beat_cnt==MSG_BEATS-1).
  - On out_v&out_p: in_p[grant_q]=1 and beat_cnt++.
  - On the eop transfer: go to IDLE, rr_ptr=grant_q+1 mod N, beat_cnt=0.
  - Source bubbles (in_v=0) hold the lock indefinitely; other sources wait.
- Restart mid-message:
  - Condition: LOCK and in_v[grant_q]&in_s[grant_q].
  - set err_sync[grant_q]; that beat is emitted as sop=1 of a new message and beat_cnt restarts at 1. If MSG_BEATS==1 it is also eop and the FSM returns to IDLE.
  - The partial message is not closed; downstream detects it by the sop without a preceding eop.
- Restart in IDLE is a normal sop.
- Datapath latency:
  - Zero cycles, combinational mux from in_* to out_*.
  - in_p depends combinationally on out_p. Sources must not drive in_v from in_p.
- Beats are never dropped or duplicated; in_p is never asserted when in_v is low.
- Wrap-around: rr_ptr wraps N-1 to 0; beat_cnt never exceeds MSG_BEATS-1 in LOCK.
- rst asserted mid-message: state returns to IDLE, the partial message is abandoned, and err_sync is cleared.

Optional Feature:
- Macro: PCIE_INORDER_ARB_STATS_EN.
- Defined:
  - Adds output stat_msgs, N*32: per-source completed-message counters, incremented on the eop transfer, wrapping.
  - Adds output stat_stall, 32: counts cycles with out_v&!out_p, wrapping.
  - Both reset to 0.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package pcie_inorder_arb_pkg:
  - typedef arb_state_t {IDLE, LOCK}.
  - function rr_pick(req, ptr), returns found and index.
  - STAT_W=32.
- One sub-module, rr_prio_pick: combinational rotate-and-priority-encode over N requests given rr_ptr.
- The FSM, counters and mux stay in the top.

Test Plan:
- N=4, MSG_BEATS=4, all in_v=1, out_p=1 -> out_src sequence 0,0,0,0,1,1,1,1,2,...,3,0.
  - sop on beats 0/4/8/12 and eop on 3/7/11/15.
  - Exactly one in_p bit per cycle.
- Only source 2 valid, out_p toggling 1,0,1,0 -> 4 beats over 7 cycles.
  - in_p[2] high only when out_p=1; out_d equals in_d[2] each cycle.
- Source 1 locked, in_v[1] drops for 3 cycles while in_v[3]=1 -> out_v=0 those cycles, no in_p[3], and lock resumes on source 1.
- Locked on source 0 at beat_cnt=2, in_s[0] asserted -> err_sync=4'b0001, that beat has out_sop=1, and eop occurs 3 transfers later.
- rst pulsed at beat_cnt=2 -> next cycle IDLE, err_sync=0, and the arbiter picks starting from source 0.
- With PCIE_INORDER_ARB_STATS_EN, 10 messages from source 3 plus 5 stall cycles -> stat_msgs[3]=10 and stat_stall=5.
